// File: rtl/usb_tx_packet_buffer_if.sv
// usb_tx_packet_buffer_if
//   Bundles the write-side and usb_tx-side signals of the transmit packet
//   buffer so the buffer and its neighbours connect through one port.
//
//   Write side : wrData, wrValid, wrLast, wrAbort (to buffer)
//                wrReady, overflowErr, pktsPending (from buffer)
//   usb_tx side: txAcceptNewData, sending (to buffer)
//                reqSendPacket, txDataValid, txIsLastByte, txData, busy (from buffer)
//
//   slave  : the packet buffer itself
//   master : whatever drives the buffer (endpoint logic plus usb_tx, or a bench)
interface usb_tx_packet_buffer_if #(
    parameter int DEPTH_LOG2 = 7
);
    logic [7:0]          wrData;
    logic                wrValid;
    logic                wrLast;
    logic                wrReady;
    logic                wrAbort;
    logic                overflowErr;
    logic [DEPTH_LOG2:0] pktsPending;
    logic                reqSendPacket;
    logic                txAcceptNewData;
    logic                txDataValid;
    logic                txIsLastByte;
    logic [7:0]          txData;
    logic                sending;
    logic                busy;

    modport slave (
        input  wrData, wrValid, wrLast, wrAbort, txAcceptNewData, sending,
        output wrReady, overflowErr, pktsPending, reqSendPacket,
               txDataValid, txIsLastByte, txData, busy
    );

    modport master (
        output wrData, wrValid, wrLast, wrAbort, txAcceptNewData, sending,
        input  wrReady, overflowErr, pktsPending, reqSendPacket,
               txDataValid, txIsLastByte, txData, busy
    );
endinterface

// File: rtl/usb_tx_packet_buffer.sv
// usb_tx_packet_buffer
//   Packet-oriented byte FIFO sitting directly in front of the USB transmit
//   engine, clocked by the 12 MHz transmit clock. Endpoint logic writes a
//   whole packet (PID first, final byte flagged with wrLast); once the final
//   byte lands the packet is committed and the read side requests a send,
//   streams the bytes over the valid/accept handshake and then waits for the
//   engine to raise and drop 'sending' before starting the next packet.
//
//   Ports
//     clk12   : transmit clock
//     rstN    : asynchronous active-low reset
//     bus     : usb_tx_packet_buffer_if.slave
//               write side  wrData/wrValid/wrLast/wrAbort -> wrReady/overflowErr/pktsPending
//               usb_tx side txAcceptNewData/sending -> reqSendPacket/txDataValid/
//                           txIsLastByte/txData/busy
module usb_tx_packet_buffer #(
    parameter int DEPTH_LOG2 = 7
) (
    input  logic                    clk12,
    input  logic                    rstN,
    usb_tx_packet_buffer_if.slave   bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2:0] ptr_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        STREAM,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t     state_q, state_d;
    ptr_t       wrPtr_q, wrPtr_d;
    ptr_t       commitPtr_q, commitPtr_d;
    ptr_t       rdPtr_q, rdPtr_d;
    ptr_t       pkts_q, pkts_d;

    logic [8:0] mem [DEPTH];

    ptr_t       fill;
    logic       wrReadyInt;
    logic       wrAccept;
    logic       commitNow;
    logic       presenting;
    logic       xfer;
    logic       finishNow;
    logic [8:0] rdWord;

    // Occupancy only looks at registered pointers, so a byte leaving in this
    // cycle cannot make room for a byte arriving in the same cycle.
    assign fill       = wrPtr_q - rdPtr_q;
    assign wrReadyInt = (fill < ptr_t'(DEPTH));

    // An abort discards the same-cycle write silently, without an overflow.
    assign wrAccept   = bus.wrValid && wrReadyInt && !bus.wrAbort;
    assign commitNow  = wrAccept && bus.wrLast;

    assign rdWord     = mem[rdPtr_q[DEPTH_LOG2-1:0]];

    // The commit pointer guard keeps uncommitted bytes from ever being shown.
    assign presenting = ((state_q == REQ) || (state_q == STREAM)) && (rdPtr_q != commitPtr_q);
    assign xfer       = presenting && bus.txAcceptNewData;
    assign finishNow  = xfer && rdWord[8];

    assign bus.wrReady       = wrReadyInt;
    assign bus.overflowErr   = bus.wrValid && !wrReadyInt && !bus.wrAbort;
    assign bus.pktsPending   = pkts_q;
    assign bus.reqSendPacket = (state_q == REQ);
    assign bus.txDataValid   = presenting;
    assign bus.txIsLastByte  = presenting && rdWord[8];
    assign bus.txData        = presenting ? rdWord[7:0] : 8'h00;
    assign bus.busy          = (state_q != IDLE);

    // Byte storage; contents deliberately survive reset.
    always_ff @(posedge clk12) begin
        if (wrAccept) begin
            mem[wrPtr_q[DEPTH_LOG2-1:0]] <= {bus.wrLast, bus.wrData};
        end
    end

    // Pointer and packet-count next state.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        commitPtr_d = commitPtr_q;
        rdPtr_d     = rdPtr_q;
        pkts_d      = pkts_q;

        if (bus.wrAbort) begin
            wrPtr_d = commitPtr_q;
        end else if (wrAccept) begin
            wrPtr_d = wrPtr_q + ptr_t'(1);
            if (bus.wrLast) begin
                commitPtr_d = wrPtr_q + ptr_t'(1);
            end
        end

        if (xfer) begin
            rdPtr_d = rdPtr_q + ptr_t'(1);
        end

        // A commit and a finished packet in the same cycle cancel out.
        if (commitNow && !finishNow) begin
            pkts_d = pkts_q + ptr_t'(1);
        end else if (!commitNow && finishNow) begin
            pkts_d = pkts_q - ptr_t'(1);
        end
    end

    // Read-side sequencing: request, stream, then wait for the engine's
    // sending pulse to rise and fall so the EOP finishes before a new start.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if ((pkts_q != '0) && !bus.sending) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = finishNow ? WAIT_HI : STREAM;
            end
            STREAM: begin
                if (finishNow) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (bus.sending) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!bus.sending) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk12 or negedge rstN) begin
        if (!rstN) begin
            state_q     <= IDLE;
            wrPtr_q     <= '0;
            commitPtr_q <= '0;
            rdPtr_q     <= '0;
            pkts_q      <= '0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            commitPtr_q <= commitPtr_d;
            rdPtr_q     <= rdPtr_d;
            pkts_q      <= pkts_d;
        end
    end

endmodule

// File: tb/tb_usb_tx_packet_buffer.sv
// tb_usb_tx_packet_buffer
//   Drives usb_tx_packet_buffer through directed packet scenarios and a
//   randomized phase. A behavioural model holds committed bytes and the
//   packet currently being written as queues, tracks where the usb_tx
//   handshake should be, and every cycle predicts the buffer's outputs.
//   A small usb_tx stand-in accepts bytes and pulses 'sending'.
module tb_usb_tx_packet_buffer;

    localparam int DEPTH_LOG2 = 7;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic clk12;
    logic rstN;

    usb_tx_packet_buffer_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    usb_tx_packet_buffer #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk12 (clk12),
        .rstN  (rstN),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [8:0] expQ[$];
    logic [8:0] pendQ[$];
    int         pendCount  = 0;
    bit         inPacket   = 0;
    bit         waitRise   = 0;
    bit         waitFall   = 0;
    bit         expReq     = 0;
    bit         monOn      = 0;
    int         reqCount   = 0;
    int         lastCount  = 0;

    // usb_tx stand-in controls
    int         acceptMode  = 0;
    bit         holdSending = 0;
    bit         reqSeen     = 0;
    bit         lastSeen    = 0;
    bit         txActive    = 0;
    int         eopCnt      = 0;
    bit         acceptToggle = 0;

    initial clk12 = 1'b0;
    always #5 clk12 = ~clk12;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit l, input bit a);
        bus.wrValid = v;
        bus.wrData  = d;
        bus.wrLast  = l;
        bus.wrAbort = a;
        @(posedge clk12);
        #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic writePacket(input logic [7:0] bytes[$]);
        foreach (bytes[i]) applyStimulus(1'b1, bytes[i], (i == bytes.size() - 1), 1'b0);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((pendCount != 0 || inPacket || waitRise || waitFall || expReq) && n < budget) begin
            idleCycles(1);
            n++;
        end
        checkOutput(tag, (n >= budget), 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput($sformatf("%s.wrReady", tag),       bus.wrReady,       1);
        checkOutput($sformatf("%s.reqSendPacket", tag), bus.reqSendPacket, 0);
        checkOutput($sformatf("%s.txDataValid", tag),   bus.txDataValid,   0);
        checkOutput($sformatf("%s.txIsLastByte", tag),  bus.txIsLastByte,  0);
        checkOutput($sformatf("%s.txData", tag),        bus.txData,        0);
        checkOutput($sformatf("%s.busy", tag),          bus.busy,          0);
        checkOutput($sformatf("%s.overflowErr", tag),   bus.overflowErr,   0);
        checkOutput($sformatf("%s.pktsPending", tag),   bus.pktsPending,   0);
    endtask

    task automatic clearModel();
        expQ.delete();
        pendQ.delete();
        pendCount = 0;
        inPacket  = 0;
        waitRise  = 0;
        waitFall  = 0;
        expReq    = 0;
    endtask

    // Cycle monitor: compares outputs with the model half a cycle before the
    // edge, then advances the model by what that edge will do.
    initial begin
        forever begin
            @(negedge clk12);
            if (rstN && monOn) begin
                automatic int  fillNow = expQ.size() + pendQ.size();
                automatic bit  readyNow = (fillNow < DEPTH);
                automatic bit  idleNow = !inPacket && !waitRise && !waitFall;
                automatic bit  doReq;
                automatic bit  xfer = 0;
                automatic bit  xferLast = 0;
                automatic bit  wrAcc;

                checkOutput("wrReady",       bus.wrReady,       readyNow);
                checkOutput("overflowErr",   bus.overflowErr,   bus.wrValid && !readyNow && !bus.wrAbort);
                checkOutput("pktsPending",   bus.pktsPending,   pendCount);
                checkOutput("reqSendPacket", bus.reqSendPacket, expReq);
                checkOutput("txDataValid",   bus.txDataValid,   inPacket);
                checkOutput("busy",          bus.busy,          !idleNow);
                if (inPacket) begin
                    checkOutput("streamHasData", (expQ.size() > 0), 1);
                    if (expQ.size() > 0) begin
                        checkOutput("txData",       bus.txData,       expQ[0][7:0]);
                        checkOutput("txIsLastByte", bus.txIsLastByte, expQ[0][8]);
                        xfer     = bus.txAcceptNewData;
                        xferLast = xfer && expQ[0][8];
                    end
                end

                reqSeen  = bus.reqSendPacket;
                lastSeen = bus.txDataValid && bus.txAcceptNewData && bus.txIsLastByte;
                if (bus.reqSendPacket) reqCount++;

                doReq = idleNow && (pendCount != 0) && !bus.sending;

                if (waitRise && bus.sending) begin
                    waitRise = 0;
                    waitFall = 1;
                end else if (waitFall && !bus.sending) begin
                    waitFall = 0;
                end

                if (xfer) begin
                    void'(expQ.pop_front());
                    if (xferLast) begin
                        pendCount--;
                        inPacket = 0;
                        waitRise = 1;
                        lastCount++;
                    end
                end

                wrAcc = bus.wrValid && readyNow && !bus.wrAbort;
                if (bus.wrAbort) begin
                    pendQ.delete();
                end else if (wrAcc) begin
                    pendQ.push_back({bus.wrLast, bus.wrData});
                    if (bus.wrLast) begin
                        foreach (pendQ[i]) expQ.push_back(pendQ[i]);
                        pendQ.delete();
                        pendCount++;
                    end
                end

                if (doReq) inPacket = 1;
                expReq = doReq;
            end
        end
    end

    // usb_tx stand-in: sending rises after a request and falls a few cycles
    // after the final byte, unless held high by the test.
    initial begin
        bus.txAcceptNewData = 1'b0;
        bus.sending         = 1'b0;
        forever begin
            @(posedge clk12);
            #1;
            if (!rstN) begin
                txActive = 0;
                eopCnt   = 0;
            end else begin
                if (reqSeen) txActive = 1;
                if (lastSeen) begin
                    eopCnt = 3;
                end else if (eopCnt > 0) begin
                    eopCnt--;
                    if (eopCnt == 0) txActive = 0;
                end
            end
            reqSeen      = 0;
            lastSeen     = 0;
            bus.sending  = txActive || holdSending;
            acceptToggle = !acceptToggle;
            case (acceptMode)
                0:       bus.txAcceptNewData = 1'b1;
                1:       bus.txAcceptNewData = acceptToggle;
                default: bus.txAcceptNewData = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] pkt[$];
        int         baseReq;
        int         baseLast;
        int         n;

        bus.wrValid = 1'b0;
        bus.wrData  = 8'h00;
        bus.wrLast  = 1'b0;
        bus.wrAbort = 1'b0;
        rstN = 1'b1;
        #1 rstN = 1'b0;
        #1 checkResetOutputs("reset0");
        repeat (3) @(posedge clk12);
        #1;
        rstN  = 1'b1;
        monOn = 1;

        // Five-byte packet, engine accepting every other cycle
        acceptMode = 1;
        pkt = '{8'hC3, 8'h01, 8'h02, 8'hAA, 8'h55};
        writePacket(pkt);
        drain("t1Drain", 200);
        checkOutput("t1ReqCount", reqCount, 1);
        checkOutput("t1LastCount", lastCount, 1);

        // Single-byte handshake packet
        acceptMode = 0;
        pkt = '{8'hD2};
        writePacket(pkt);
        drain("t2Drain", 200);
        checkOutput("t2ReqCount", reqCount, 2);

        // Aborted partial packet followed by a real one
        applyStimulus(1'b1, 8'hE1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hE2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hE3, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        pkt = '{8'h69, 8'h10, 8'h20};
        writePacket(pkt);
        drain("t3Drain", 200);
        checkOutput("t3ReqCount", reqCount, 3);

        // Fill with one uncommitted packet, overflow, recover by abort
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        bus.wrValid = 1'b1;
        bus.wrData  = 8'hEE;
        #2;
        checkOutput("t4Full", bus.wrReady, 0);
        checkOutput("t4Overflow", bus.overflowErr, 1);
        @(posedge clk12);
        #1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        #2;
        checkOutput("t4Recovered", bus.wrReady, 1);
        checkOutput("t4NoPending", bus.pktsPending, 0);
        @(posedge clk12);
        #1;
        idleCycles(2);
        checkOutput("t4ReqCount", reqCount, 3);

        // Two packets across the pointer wrap with sending held high
        baseReq = reqCount;
        pkt = {};
        pkt.push_back(8'hC3);
        for (int i = 1; i < 64; i++) pkt.push_back(8'($urandom));
        writePacket(pkt);
        n = 0;
        while (reqCount == baseReq && n < 20) begin
            idleCycles(1);
            n++;
        end
        checkOutput("t5FirstReq", reqCount, baseReq + 1);
        holdSending = 1;
        pkt = {};
        pkt.push_back(8'h4B);
        for (int i = 1; i < 64; i++) pkt.push_back(8'($urandom));
        writePacket(pkt);
        idleCycles(80);
        checkOutput("t5Held", reqCount, baseReq + 1);
        holdSending = 0;
        drain("t5Drain", 400);
        checkOutput("t5ReqCount", reqCount, baseReq + 2);

        // Reset in the middle of streaming
        acceptMode = 1;
        pkt = {};
        pkt.push_back(8'h87);
        for (int i = 1; i < 20; i++) pkt.push_back(8'($urandom));
        writePacket(pkt);
        n = 0;
        while (!(inPacket && expQ.size() <= 14) && n < 100) begin
            idleCycles(1);
            n++;
        end
        checkOutput("t6ReachedStream", (n < 100), 1);
        baseReq = reqCount;
        #2 rstN = 1'b0;
        #1 checkResetOutputs("midReset");
        clearModel();
        @(posedge clk12);
        #1;
        idleCycles(2);
        rstN = 1'b1;
        idleCycles(30);
        checkOutput("t6NoReq", reqCount, baseReq);

        // Randomized traffic
        acceptMode = 2;
        baseReq  = reqCount;
        baseLast = lastCount;
        for (int c = 0; c < 800; c++) begin
            automatic int r = $urandom_range(0, 99);
            if (r < 3)       applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b1);
            else if (r < 70) applyStimulus(1'b1, 8'($urandom), ($urandom_range(0, 19) == 0), 1'b0);
            else             idleCycles(1);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        drain("t7Drain", 4000);
        checkOutput("t7Pkts", reqCount - baseReq, lastCount - baseLast);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
